// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: one bit position per clock, valid/ready on both sides,
// result returned with carry, zero, overflow and illegal-opcode flags.
module seq_shift_unit #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [2:0]         opc,
  input  logic [SHAMT_W-1:0] amt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic               carry,
  output logic               zero,
  output logic               ovf,
  output logic               err
);

  localparam int N = WIDTH - 1;
  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  localparam logic [2:0] OP_ROTL = 3'd0;
  localparam logic [2:0] OP_SLA  = 3'd1;
  localparam logic [2:0] OP_SRA  = 3'd2;
  localparam logic [2:0] OP_SRL  = 3'd3;
  localparam logic [2:0] OP_ROTR = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [WIDTH-1:0]     work_r, work_nxt_s;
  logic [SHAMT_W-1:0]   count_r, count_nxt_s;
  logic [2:0]           opc_r, opc_nxt_s;
  logic                 carry_r, carry_nxt_s;
  logic                 zero_r, zero_nxt_s;
  logic                 ovf_r, ovf_nxt_s;
  logic                 err_r, err_nxt_s;
  logic                 illegal_s;

  assign illegal_s = (opc > OP_ROTR);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath next values; the opcode is held in opc_r so later input changes are ignored
  always_comb begin
    state_nxt_s = state_r;
    work_nxt_s  = work_r;
    count_nxt_s = count_r;
    opc_nxt_s   = opc_r;
    carry_nxt_s = carry_r;
    zero_nxt_s  = zero_r;
    ovf_nxt_s   = ovf_r;
    err_nxt_s   = err_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          work_nxt_s  = A;
          opc_nxt_s   = opc;
          count_nxt_s = amt;
          carry_nxt_s = 1'b0;
          ovf_nxt_s   = 1'b0;
          err_nxt_s   = illegal_s;
          zero_nxt_s  = (A == '0);
          state_nxt_s = (illegal_s || (amt == '0)) ? DONE : SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        case (opc_r)
          OP_ROTL: begin
            work_nxt_s  = {work_r[N-1:0], work_r[N]};
            carry_nxt_s = work_r[N];
          end
          OP_SLA: begin
            work_nxt_s  = {work_r[N-1:0], 1'b0};
            carry_nxt_s = work_r[N];
            ovf_nxt_s   = ovf_r | (work_r[N] ^ work_r[N-1]);
          end
          OP_SRA: begin
            work_nxt_s  = {work_r[N], work_r[N:1]};
            carry_nxt_s = work_r[0];
          end
          OP_SRL: begin
            work_nxt_s  = {1'b0, work_r[N:1]};
            carry_nxt_s = work_r[0];
          end
          OP_ROTR: begin
            work_nxt_s  = {work_r[0], work_r[N:1]};
            carry_nxt_s = work_r[0];
          end
          default: begin
            work_nxt_s  = work_r;
            carry_nxt_s = carry_r;
          end
        endcase
        zero_nxt_s  = (work_nxt_s == '0);
        count_nxt_s = count_r - CNT_ONE;
        if (count_r == CNT_ONE) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Working register, count and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_r  <= '0;
      count_r <= '0;
      opc_r   <= 3'd0;
      carry_r <= 1'b0;
      zero_r  <= 1'b0;
      ovf_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      work_r  <= work_nxt_s;
      count_r <= count_nxt_s;
      opc_r   <= opc_nxt_s;
      carry_r <= carry_nxt_s;
      zero_r  <= zero_nxt_s;
      ovf_r   <= ovf_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign out       = work_r;
  assign carry     = carry_r;
  assign zero      = zero_r;
  assign ovf       = ovf_r;
  assign err       = err_r;

endmodule
